// File: rtl/noc_e1of2_tx.sv
// Transmitter for a four-phase dual-rail (one-of-two per digit) NoC channel.
// Binary words queue in a small FIFO and are launched as codewords against a synchronized receiver enable.
module noc_e1of2_tx #(
    parameter int M     = 9,
    parameter int DEPTH = 4,
    parameter int SYNC  = 2
) (
    input  logic           CLK,
    input  logic           _RESET,
    input  logic [M-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*M-1:0] out_d,
    input  logic           out_e,
    output logic           busy,
    output logic [15:0]    sent_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {NEUTRAL = 1'b0, DATA = 1'b1} state_t;

    state_t          state;
    logic [SYNC-1:0] e_sync;
    logic            e_s;
    logic [M-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    function automatic logic [2*M-1:0] encode(input logic [M-1:0] word);
        logic [2*M-1:0] code;
        code = '0;
        for (int i = 0; i < M; i++) begin
            code[2*i+1] = word[i];
            code[2*i]   = ~word[i];
        end
        return code;
    endfunction

    // out_e is asynchronous to CLK; nothing looks at it before the last stage
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) e_sync <= '0;
        else         e_sync <= {e_sync[SYNC-2:0], out_e};
    end

    assign e_s      = e_sync[SYNC-1];
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == NEUTRAL) && (count != '0) && e_s;
    assign busy     = (count != '0) || (state == DATA);

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Return-to-zero handshake: launch only on e_s=1, go neutral only on e_s=0
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state    <= NEUTRAL;
            out_d    <= '0;
            sent_cnt <= '0;
        end else begin
            case (state)
                NEUTRAL: begin
                    if (pop) begin
                        out_d <= encode(mem[rd_ptr]);
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (!e_s) begin
                        out_d    <= '0;
                        sent_cnt <= sent_cnt + 16'd1;
                        state    <= NEUTRAL;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_e1of2_tx.sv
// Directed bench for noc_e1of2_tx: single token, backpressure, ordering, push-on-pop,
// reset mid-token and counter wrap, with hand-computed dual-rail codewords.
module tb_noc_e1of2_tx;
    localparam int M = 9;

    logic           CLK;
    logic           _RESET;
    logic [M-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [2*M-1:0] out_d;
    logic           out_e;
    logic           busy;
    logic [15:0]    sent_cnt;

    int errors = 0;
    int checks = 0;

    logic [M-1:0]   fill_words [4] = '{9'h001, 9'h002, 9'h004, 9'h008};
    logic [2*M-1:0] raw;
    logic           ok;

    noc_e1of2_tx #(.M(M), .DEPTH(4), .SYNC(2)) dut (
        .CLK      (CLK),
        ._RESET   (_RESET),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_d    (out_d),
        .out_e    (out_e),
        .busy     (busy),
        .sent_cnt (sent_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {codeword_ok, value}; any digit with both or neither rail high is invalid
    function automatic logic [M:0] decode(input logic [2*M-1:0] code);
        logic [M-1:0] val;
        logic         good;
        val  = '0;
        good = 1'b1;
        for (int i = 0; i < M; i++) begin
            case (code[2*i +: 2])
                2'b10:   val[i] = 1'b1;
                2'b01:   val[i] = 1'b0;
                default: good = 1'b0;
            endcase
        end
        return {good, val};
    endfunction

    task automatic push(input logic [M-1:0] w);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Receiver model: wait for a codeword, withdraw enable, wait for neutral, re-enable
    task automatic recv(output logic [2*M-1:0] code, output logic good);
        good = 1'b1;
        for (int i = 0; i < 40 && out_d == '0; i++) tick();
        code = out_d;
        if (out_d == '0) good = 1'b0;
        out_e = 1'b0;
        for (int i = 0; i < 40 && out_d != '0; i++) tick();
        if (out_d != '0) good = 1'b0;
        out_e = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        _RESET   = 1'b0;
        out_e    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) tick();
        chk("rst_out_d", out_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent_cnt", sent_cnt, 0);
        _RESET = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // single token 0x1A5, one-edge launch latency, neutral after enable drops
        out_e = 1'b1;
        repeat (3) tick();
        push(9'h1A5);
        chk("t1_edge_n_neutral", out_d, 0);
        chk("t1_busy_queued", busy, 1);
        tick();
        chk("t1_codeword", out_d, 18'b10_10_01_10_01_01_10_01_10);
        out_e = 1'b0;
        repeat (2) tick();
        chk("t1_hold_in_sync", out_d, 18'b10_10_01_10_01_01_10_01_10);
        tick();
        chk("t1_neutral", out_d, 0);
        chk("t1_sent_cnt", sent_cnt, 1);
        chk("t1_idle", busy, 0);

        // backpressure: enable stays high, first token parked, FIFO fills, extra word rejected
        out_e = 1'b1;
        repeat (3) tick();
        push(9'h123);
        tick();
        chk("t2_first", out_d, 18'b10_01_01_10_01_01_01_10_10);
        for (int i = 0; i < 4; i++) begin
            chk("t2_ready_before_fill", in_ready, 1);
            push(fill_words[i]);
        end
        chk("t2_full", in_ready, 0);
        in_data  = 9'h1FF;
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        chk("t2_still_full", in_ready, 0);
        chk("t2_out_stable", out_d, 18'b10_01_01_10_01_01_01_10_10);
        recv(raw, ok);
        chk("t2_recv0_ok", ok, 1);
        chk("t2_recv0", decode(raw), {1'b1, 9'h123});
        for (int i = 0; i < 4; i++) begin
            recv(raw, ok);
            chk("t2_drain_ok", ok, 1);
            chk("t2_drain", decode(raw), {1'b1, fill_words[i]});
        end
        repeat (10) tick();
        chk("t2_rejected_not_sent", out_d, 0);
        chk("t2_busy", busy, 0);
        chk("t2_sent_cnt", sent_cnt, 6);

        // ordering with extreme patterns
        in_valid = 1'b1;
        in_data  = 9'h000; tick();
        in_data  = 9'h1FF; tick();
        in_data  = 9'h155; tick();
        in_valid = 1'b0;
        recv(raw, ok);
        chk("t3_ok0", ok, 1);
        chk("t3_code0", raw, 18'b01_01_01_01_01_01_01_01_01);
        recv(raw, ok);
        chk("t3_ok1", ok, 1);
        chk("t3_code1", raw, 18'b10_10_10_10_10_10_10_10_10);
        recv(raw, ok);
        chk("t3_ok2", ok, 1);
        chk("t3_code2", raw, 18'b10_01_10_01_10_01_10_01_10);
        chk("t3_dec2", decode(raw), {1'b1, 9'h155});
        chk("t3_busy", busy, 0);
        chk("t3_sent_cnt", sent_cnt, 9);

        // push lands on the pop edge of a one-word FIFO
        repeat (3) tick();
        in_valid = 1'b1;
        in_data  = 9'h0F0; tick();
        in_data  = 9'h10F; tick();
        in_valid = 1'b0;
        chk("t4_launch_a", out_d, 18'b01_10_10_10_10_01_01_01_01);
        chk("t4_ready", in_ready, 1);
        recv(raw, ok);
        chk("t4_ok_a", ok, 1);
        recv(raw, ok);
        chk("t4_ok_b", ok, 1);
        chk("t4_dec_b", decode(raw), {1'b1, 9'h10F});
        chk("t4_busy", busy, 0);
        chk("t4_sent_cnt", sent_cnt, 11);

        // reset while a token is on the wire with another word queued
        repeat (3) tick();
        push(9'h155);
        tick();
        push(9'h0FF);
        chk("t5_in_data", out_d, 18'b10_01_10_01_10_01_10_01_10);
        #2;
        _RESET = 1'b0;
        out_e  = 1'b0;
        #1;
        chk("t5_async_neutral", out_d, 0);
        chk("t5_sent_cleared", sent_cnt, 0);
        chk("t5_busy_cleared", busy, 0);
        repeat (2) tick();
        _RESET = 1'b1;
        repeat (5) tick();
        chk("t5_nothing_sent", out_d, 0);
        chk("t5_fifo_empty", busy, 0);
        push(9'h0A5);
        repeat (3) tick();
        chk("t5_wait_enable", out_d, 0);
        chk("t5_busy_queued", busy, 1);
        out_e = 1'b1;
        repeat (2) tick();
        chk("t5_sync_delay", out_d, 0);
        tick();
        chk("t5_launch", out_d, 18'b01_10_01_10_01_01_10_01_10);
        recv(raw, ok);
        chk("t5_ok", ok, 1);
        chk("t5_sent_cnt", sent_cnt, 1);

        // counter wrap from 0xFFFF
        repeat (3) tick();
        force dut.sent_cnt = 16'hFFFF;
        tick();
        release dut.sent_cnt;
        tick();
        push(9'h0C3);
        recv(raw, ok);
        chk("t6_ok0", ok, 1);
        chk("t6_wrap", sent_cnt, 16'h0000);
        push(9'h03C);
        recv(raw, ok);
        chk("t6_ok1", ok, 1);
        chk("t6_dec1", decode(raw), {1'b1, 9'h03C});
        chk("t6_after_wrap", sent_cnt, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
